regfile_pipe: RTL and testbench
===============================

Name: regfile_pipe

Overview:
- Parametrised successor to the single-cycle 32x32 register file, for the pipelined datapath.
- Two read ports and two write ports: the main writeback port and a dedicated link port for jal.
- Adds write-to-read bypass, a per-register busy scoreboard for hazard detection, and a reset-time clear sweep that restores the stack-pointer init value.
- Sits between the decode and writeback stages; hazard logic consumes ready/busy1/busy2.

Parameters:
N, 32, data width in bits
R, 5, address width; depth = 2**R registers
SP_INDEX, 29, register loaded with SP_INIT by the clear sweep
SP_INIT, 32'h7ffffffc, stack-pointer reset value (N bits)
LINK_INDEX, 31, destination of link-port writes
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns stored value

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
ready  out  1  high when the clear sweep is done and the file accepts traffic
we  in  1  writeback write enable
wa  in  R  writeback address
wd  in  N  writeback data
link_we  in  1  link write enable (jal)
link_pc  in  N  link data (pc+4)
ra1  in  R  read address 1
ra2  in  R  read address 2
rd1  out  N  read data 1 (combinational)
rd2  out  N  read data 2 (combinational)
rsv_en  in  1  reserve destination register (issue of a writing instruction)
rsv_addr  in  R  register to mark busy
busy1  out  1  register ra1 has a pending write
busy2  out  1  register ra2 has a pending write

Behaviour:
- The file has two states, CLEAR and RUN.
- reset=1 at an edge: enter CLEAR with sweep index 0 and clear all busy bits. This applies from either state; a reset mid-sweep restarts the sweep at index 0.
- CLEAR: one register written per cycle, index 0 up to 2**R-1. SP_INDEX is written with SP_INIT; every other register is written with 0.
- CLEAR to RUN: after the edge that writes index 2**R-1. The sweep takes exactly 2**R cycles after reset deasserts, then ready=1.
- During CLEAR:
  - ready=0, rd1=rd2=0, busy1=busy2=0.
  - we, link_we and rsv_en are ignored.
- RUN, writes:
  - we=1 writes rf[wa]<=wd.
  - link_we=1 writes rf[LINK_INDEX]<=link_pc.
  - Both are allowed in the same cycle. If we=1 and wa==LINK_INDEX, the writeback port wins and the link write is dropped.
- Register 0 reads always return 0. Writes to address 0 are discarded, and a reserve of 0 is discarded.
- Reads are combinational. With BYPASS=1, if a read address is non-zero and matches an enabled write this cycle, rd returns the incoming data, using the same priority as the writes. With BYPASS=0, rd returns the stored value.
- Scoreboard, one busy bit per register:
  - rsv_en sets busy[rsv_addr].
  - A committed we write clears busy[wa].
  - A link write clears busy[LINK_INDEX].
  - If a reserve and a clear hit the same register in one cycle, the reserve wins and the bit stays 1.
- busy1/busy2 = busy[ra1]/busy[ra2]. With BYPASS=1 the busy output is masked to 0 when the bypass path for that port is active in the same cycle.
- Reset values: ready=0, busy bits=0, rd1/rd2=0 until ready.
- Latency: write-to-read is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0. Reserve-to-busy is 1 cycle.

Test Plan:
- Reset sweep: pulse reset 1 cycle, then hold idle -> ready=0 for exactly 32 cycles, then 1. Read ra1=29 -> 32'h7ffffffc; ra2=5 -> 0. Repeat with reset reasserted at sweep cycle 10 -> ready rises 32 cycles after that deassertion.
- Write/read and bypass: we=1, wa=8, wd=32'hDEADBEEF, ra1=8 in the same cycle -> rd1=32'hDEADBEEF that cycle (BYPASS=1); rerun with BYPASS=0 -> old value 0 that cycle, DEADBEEF the next.
- Register 0: we=1, wa=0, wd=32'h1234 -> rd1 with ra1=0 stays 0. rsv_en with rsv_addr=0 -> busy1 stays 0.
- Dual write priority: we=1, wa=31, wd=32'hAAAA0000 with link_we=1, link_pc=32'h00400010 -> rf[31]=32'hAAAA0000. Next cycle link_we alone, link_pc=32'h00400020 -> rf[31]=32'h00400020.
- Scoreboard: rsv_en, rsv_addr=12 -> busy1 (ra1=12) rises next cycle. Reserve 12 again while we=1, wa=12 in the same cycle -> busy stays 1. A later we to 12 alone -> busy clears. A bypass-active cycle shows busy1=0.
- Ignore during CLEAR: we=1, wa=4, wd=7 and rsv_en on 4 during the sweep -> after ready, rf[4]=0 and busy=0.

Source files
------------

// File: rtl/regfile_pipe_if.sv
// Decode/writeback-facing bus of the pipelined register file: two read ports,
// writeback and link write ports, scoreboard reserve and hazard status.
interface regfile_pipe_if #(
    parameter int N = 32,
    parameter int R = 5
);
    logic         ready;
    logic         we;
    logic [R-1:0] wa;
    logic [N-1:0] wd;
    logic         link_we;
    logic [N-1:0] link_pc;
    logic [R-1:0] ra1;
    logic [R-1:0] ra2;
    logic [N-1:0] rd1;
    logic [N-1:0] rd2;
    logic         rsv_en;
    logic [R-1:0] rsv_addr;
    logic         busy1;
    logic         busy2;

    modport master (
        input  ready, rd1, rd2, busy1, busy2,
        output we, wa, wd, link_we, link_pc, ra1, ra2, rsv_en, rsv_addr
    );

    modport slave (
        output ready, rd1, rd2, busy1, busy2,
        input  we, wa, wd, link_we, link_pc, ra1, ra2, rsv_en, rsv_addr
    );
endinterface

// File: rtl/regfile_pipe.sv
// Pipelined register file: 2 read / 2 write ports, optional write-to-read bypass,
// per-register busy scoreboard and a post-reset clear sweep that seeds the stack pointer.
module regfile_pipe #(
    parameter int           N          = 32,
    parameter int           R          = 5,
    parameter int           SP_INDEX   = 29,
    parameter logic [N-1:0] SP_INIT    = 32'h7ffffffc,
    parameter int           LINK_INDEX = 31,
    parameter int           BYPASS     = 1
) (
    input  logic           clk,
    input  logic           reset,
    regfile_pipe_if.slave  bus
);
    localparam int           DEPTH  = 2 ** R;
    localparam logic [R-1:0] SP_A   = R'(SP_INDEX);
    localparam logic [R-1:0] LINK_A = R'(LINK_INDEX);
    localparam logic [R-1:0] LAST_A = R'(DEPTH - 1);
    localparam bit           BYP_ON = (BYPASS != 0);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [R-1:0]     idx_q, idx_d;
    logic             ready_q, ready_d;
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [N-1:0]     rf_q [DEPTH];
    logic [N-1:0]     rf_d [DEPTH];

    logic run;
    logic rd_ok;
    logic wb_en;
    logic link_en;
    logic rsv_ok;
    logic byp1_wb, byp1_lk;
    logic byp2_wb, byp2_lk;

    // Writes and reserves only take effect in RUN and never on a reset edge.
    always_comb begin
        run     = (state_q == ST_RUN) && !reset;
        rd_ok   = (state_q == ST_RUN);
        wb_en   = run && bus.we && (bus.wa != '0);
        link_en = run && bus.link_we && (LINK_A != '0)
                  && !(bus.we && (bus.wa == LINK_A));
        rsv_ok  = run && bus.rsv_en && (bus.rsv_addr != '0);
    end

    // NOTE: every signal assigned in this block gets a default first, so no latches.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        rf_d    = rf_q;
        case (state_q)
            ST_CLEAR: begin
                rf_d[idx_q] = (idx_q == SP_A) ? SP_INIT : '0;
                idx_d       = idx_q + R'(1);
                if (idx_q == LAST_A) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Link first so a same-address writeback overrides it.
                if (link_en) begin
                    rf_d[LINK_A]   = bus.link_pc;
                    busy_d[LINK_A] = 1'b0;
                end
                if (wb_en) begin
                    rf_d[bus.wa]   = bus.wd;
                    busy_d[bus.wa] = 1'b0;
                end
                if (rsv_ok) begin
                    busy_d[bus.rsv_addr] = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: the array has no reset term; the clear sweep initialises it, which keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

    always_comb begin
        byp1_wb = BYP_ON && wb_en && (bus.wa == bus.ra1);
        byp1_lk = BYP_ON && link_en && (bus.ra1 == LINK_A);
        byp2_wb = BYP_ON && wb_en && (bus.wa == bus.ra2);
        byp2_lk = BYP_ON && link_en && (bus.ra2 == LINK_A);
    end

    always_comb begin
        if (!rd_ok || bus.ra1 == '0) begin
            bus.rd1 = '0;
        end else if (byp1_wb) begin
            bus.rd1 = bus.wd;
        end else if (byp1_lk) begin
            bus.rd1 = bus.link_pc;
        end else begin
            bus.rd1 = rf_q[bus.ra1];
        end
    end

    always_comb begin
        if (!rd_ok || bus.ra2 == '0) begin
            bus.rd2 = '0;
        end else if (byp2_wb) begin
            bus.rd2 = bus.wd;
        end else if (byp2_lk) begin
            bus.rd2 = bus.link_pc;
        end else begin
            bus.rd2 = rf_q[bus.ra2];
        end
    end

    // A forwarded value already satisfies the hazard, so busy is masked on bypass.
    assign bus.busy1 = rd_ok && busy_q[bus.ra1] && !(byp1_wb || byp1_lk);
    assign bus.busy2 = rd_ok && busy_q[bus.ra2] && !(byp2_wb || byp2_lk);
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_regfile_pipe.sv
// Directed bench for regfile_pipe: one BYPASS=1 and one BYPASS=0 instance share
// the same stimulus; expected values are hand-computed constants.
module tb_regfile_pipe;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   cyc;

    regfile_pipe_if #(.N(32), .R(5)) bus ();
    regfile_pipe_if #(.N(32), .R(5)) bus_nb ();

    regfile_pipe #(.BYPASS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    regfile_pipe #(.BYPASS(0)) dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nb.slave)
    );

    assign bus_nb.we       = bus.we;
    assign bus_nb.wa       = bus.wa;
    assign bus_nb.wd       = bus.wd;
    assign bus_nb.link_we  = bus.link_we;
    assign bus_nb.link_pc  = bus.link_pc;
    assign bus_nb.ra1      = bus.ra1;
    assign bus_nb.ra2      = bus.ra2;
    assign bus_nb.rsv_en   = bus.rsv_en;
    assign bus_nb.rsv_addr = bus.rsv_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we       = 1'b0;
        bus.wa       = '0;
        bus.wd       = '0;
        bus.link_we  = 1'b0;
        bus.link_pc  = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
    endtask

    task automatic wait_ready();
        while (!bus.ready && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle();
        bus.ra1 = '0;
        bus.ra2 = '0;
        reset   = 1'b1;

        // Reset sweep with writes/reserves that must be ignored during CLEAR
        tick();
        reset = 1'b0;
        cyc   = 0;
        check("ready_after_reset", 32'(bus.ready), 32'd0);
        bus.we       = 1'b1;
        bus.wa       = 5'd4;
        bus.wd       = 32'd7;
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd4;
        bus.ra1      = 5'd4;
        bus.ra2      = 5'd29;
        #1;
        check("clear_rd1_zero", bus.rd1, 32'd0);
        check("clear_rd2_zero", bus.rd2, 32'd0);
        check("clear_busy1_zero", 32'(bus.busy1), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            cyc++;
        end
        idle();
        wait_ready();
        check("sweep_cycles", 32'(cyc), 32'd32);
        check("sweep_cycles_nb", 32'(bus_nb.ready), 32'd1);
        bus.ra1 = 5'd29;
        bus.ra2 = 5'd5;
        #1;
        check("sp_init", bus.rd1, 32'h7ffffffc);
        check("r5_zero", bus.rd2, 32'd0);
        bus.ra1 = 5'd4;
        #1;
        check("r4_ignored", bus.rd1, 32'd0);
        check("r4_busy_ignored", 32'(bus.busy1), 32'd0);

        // Reset reasserted mid-sweep restarts the 32-cycle sweep
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ready_drop", 32'(bus.ready), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc   = 0;
        wait_ready();
        check("resweep_cycles", 32'(cyc), 32'd32);
        bus.ra1 = 5'd29;
        #1;
        check("sp_init_resweep", bus.rd1, 32'h7ffffffc);

        // Write/read with and without bypass
        bus.we  = 1'b1;
        bus.wa  = 5'd8;
        bus.wd  = 32'hDEADBEEF;
        bus.ra1 = 5'd8;
        #1;
        check("bypass_same_cycle", bus.rd1, 32'hDEADBEEF);
        check("nobypass_same_cycle", bus_nb.rd1, 32'd0);
        tick();
        idle();
        #1;
        check("bypass_next_cycle", bus.rd1, 32'hDEADBEEF);
        check("nobypass_next_cycle", bus_nb.rd1, 32'hDEADBEEF);

        // Register 0 is hardwired
        bus.we  = 1'b1;
        bus.wa  = 5'd0;
        bus.wd  = 32'h1234;
        bus.ra1 = 5'd0;
        #1;
        check("r0_bypass", bus.rd1, 32'd0);
        tick();
        idle();
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd0;
        #1;
        check("r0_read", bus.rd1, 32'd0);
        tick();
        idle();
        #1;
        check("r0_busy", 32'(bus.busy1), 32'd0);

        // Dual write priority on register 31
        bus.we      = 1'b1;
        bus.wa      = 5'd31;
        bus.wd      = 32'hAAAA0000;
        bus.link_we = 1'b1;
        bus.link_pc = 32'h00400010;
        bus.ra2     = 5'd31;
        #1;
        check("dual_bypass", bus.rd2, 32'hAAAA0000);
        tick();
        idle();
        #1;
        check("dual_stored", bus.rd2, 32'hAAAA0000);
        check("dual_stored_nb", bus_nb.rd2, 32'hAAAA0000);
        bus.link_we = 1'b1;
        bus.link_pc = 32'h00400020;
        #1;
        check("link_bypass", bus.rd2, 32'h00400020);
        check("link_nobypass", bus_nb.rd2, 32'hAAAA0000);
        tick();
        idle();
        #1;
        check("link_stored", bus.rd2, 32'h00400020);
        check("link_stored_nb", bus_nb.rd2, 32'h00400020);

        // Scoreboard on register 12
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd12;
        bus.ra1      = 5'd12;
        #1;
        check("rsv_not_yet", 32'(bus.busy1), 32'd0);
        tick();
        idle();
        #1;
        check("rsv_busy", 32'(bus.busy1), 32'd1);
        check("rsv_busy_nb", 32'(bus_nb.busy1), 32'd1);
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd12;
        bus.we       = 1'b1;
        bus.wa       = 5'd12;
        bus.wd       = 32'h55;
        #1;
        check("busy_masked_bypass", 32'(bus.busy1), 32'd0);
        check("busy_unmasked_nb", 32'(bus_nb.busy1), 32'd1);
        tick();
        idle();
        #1;
        check("rsv_wins", 32'(bus.busy1), 32'd1);
        check("rsv_wins_nb", 32'(bus_nb.busy1), 32'd1);
        check("r12_data", bus.rd1, 32'h55);
        bus.we = 1'b1;
        bus.wa = 5'd12;
        bus.wd = 32'h66;
        #1;
        check("busy_masked_wb", 32'(bus.busy1), 32'd0);
        tick();
        idle();
        #1;
        check("busy_cleared", 32'(bus.busy1), 32'd0);
        check("busy_cleared_nb", 32'(bus_nb.busy1), 32'd0);
        check("r12_data2", bus_nb.rd1, 32'h66);

        // Link write clears the link-register busy bit
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd31;
        bus.ra2      = 5'd31;
        tick();
        idle();
        #1;
        check("link_busy_set", 32'(bus.busy2), 32'd1);
        bus.link_we = 1'b1;
        bus.link_pc = 32'h00400030;
        #1;
        check("link_busy_masked", 32'(bus.busy2), 32'd0);
        check("link_busy_nb", 32'(bus_nb.busy2), 32'd1);
        tick();
        idle();
        #1;
        check("link_busy_clear", 32'(bus.busy2), 32'd0);
        check("link_busy_clear_nb", 32'(bus_nb.busy2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
